// File: rtl/cnn_acc_pkg.sv
// Shared widths and arithmetic helpers for the packed-DSP result accumulator.
package cnn_acc_pkg;

  localparam int unsigned WORD_W    = 48;
  localparam int unsigned ADD_WIDTH = 19;
  localparam int unsigned KWIDTH    = 4;
  localparam int unsigned OWIDTH    = 24;
  localparam int unsigned ACC_WIDTH = ADD_WIDTH + KWIDTH;

  function automatic logic signed [ACC_WIDTH-1:0] sext_add(input logic [ADD_WIDTH-1:0] field);
    return ACC_WIDTH'(signed'(field));
  endfunction

  // Clamp to the signed range of an ow-bit result; the caller truncates to ow bits.
  function automatic logic signed [ACC_WIDTH-1:0] sat_ow(input logic signed [ACC_WIDTH-1:0] acc,
                                                         input int unsigned ow = OWIDTH);
    longint                      lim;
    logic signed [ACC_WIDTH-1:0] pos_max;
    logic signed [ACC_WIDTH-1:0] neg_min;
    if (ow >= ACC_WIDTH) return acc;
    lim     = longint'(1) <<< (ow - 1);
    pos_max = ACC_WIDTH'(lim - 1);
    neg_min = ACC_WIDTH'(-lim);
    if (acc > pos_max) return pos_max;
    if (acc < neg_min) return neg_min;
    return acc;
  endfunction

endpackage

// File: rtl/dsp_result_accum_if.sv
// Bus between the packed-DSP multiply array, the accumulator and the requant stage.
interface dsp_result_accum_if
  import cnn_acc_pkg::*;
#(
  parameter int unsigned CH_IN = 16,
  parameter int unsigned PIX   = 8,
  parameter int unsigned OUT_W = OWIDTH
);
  localparam int unsigned DATA_W = WORD_W * CH_IN * PIX;
  localparam int unsigned SUM_W  = OUT_W * 2 * CH_IN * PIX;

  logic [DATA_W-1:0] I_data;
  logic              I_data_dv;
  logic [KWIDTH-1:0] I_kx_num;
  logic              I_clear;
  logic [SUM_W-1:0]  O_data;
  logic              O_data_dv;
  logic              O_busy;

  modport master (
    output I_data, I_data_dv, I_kx_num, I_clear,
    input  O_data, O_data_dv, O_busy
  );

  modport slave (
    input  I_data, I_data_dv, I_kx_num, I_clear,
    output O_data, O_data_dv, O_busy
  );
endinterface

// File: rtl/acc_lane.sv
// One packed lane: unpack two signed products, accumulate each, saturate on the last tap.
module acc_lane
  import cnn_acc_pkg::*;
#(
  parameter int unsigned OUT_W = OWIDTH
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic [2*ADD_WIDTH-1:0] word,
  input  logic                   valid,
  input  logic                   first,
  input  logic                   last,
  input  logic                   clear,
  output logic [OUT_W-1:0]       sum_lo,
  output logic [OUT_W-1:0]       sum_hi
);

  logic signed [ACC_WIDTH-1:0] lo_q, hi_q;
  logic signed [ACC_WIDTH-1:0] acc_lo, acc_hi;
  logic signed [ACC_WIDTH-1:0] acc_lo_nxt, acc_hi_nxt;

  always_comb begin
    acc_lo_nxt = first ? lo_q : acc_lo + lo_q;
    acc_hi_nxt = first ? hi_q : acc_hi + hi_q;
  end

  // Stage 1 captures every cycle; the top's valid bit decides whether it counts.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      acc_lo <= '0;
      acc_hi <= '0;
      sum_lo <= '0;
      sum_hi <= '0;
    end else begin
      lo_q <= sext_add(word[ADD_WIDTH-1:0]);
      hi_q <= sext_add(word[2*ADD_WIDTH-1:ADD_WIDTH]);
      if (valid && !clear) begin
        acc_lo <= acc_lo_nxt;
        acc_hi <= acc_hi_nxt;
        if (last) begin
          sum_lo <= OUT_W'(sat_ow(acc_lo_nxt, OUT_W));
          sum_hi <= OUT_W'(sat_ow(acc_hi_nxt, OUT_W));
        end
      end
    end
  end

endmodule

// File: rtl/dsp_result_accum.sv
// Accumulates packed DSP products over kernel-x taps and emits one saturated sum per channel.
module dsp_result_accum
  import cnn_acc_pkg::*;
#(
  parameter int unsigned CH_IN = 16,
  parameter int unsigned PIX   = 8,
  parameter int unsigned OUT_W = OWIDTH
) (
  input logic               I_clk,
  input logic               I_rst_n,
  dsp_result_accum_if.slave bus
);

  localparam int unsigned LANES = CH_IN * PIX;

  logic [KWIDTH-1:0] cnt_k, cnt_nxt, k_q, k_nxt, k_eff;
  logic              s1_vld, s1_first, s1_last;
  logic              vld_nxt, first_nxt, last_nxt, is_last;
  logic              dv_q, busy_q;

  // Tap sequencing: K comes from I_kx_num on a group's first beat, from the latch afterwards.
  always_comb begin
    k_eff = (bus.I_kx_num == '0) ? KWIDTH'(1) : bus.I_kx_num;
    if (cnt_k != '0) k_eff = k_q;
    is_last   = (cnt_k == k_eff - KWIDTH'(1));
    cnt_nxt   = cnt_k;
    k_nxt     = k_q;
    vld_nxt   = 1'b0;
    first_nxt = s1_first;
    last_nxt  = s1_last;
    if (bus.I_clear) begin
      cnt_nxt   = '0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else if (bus.I_data_dv) begin
      vld_nxt   = 1'b1;
      first_nxt = (cnt_k == '0);
      last_nxt  = is_last;
      cnt_nxt   = is_last ? '0 : cnt_k + KWIDTH'(1);
      if (cnt_k == '0) k_nxt = k_eff;
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      cnt_k    <= '0;
      k_q      <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_k    <= cnt_nxt;
      k_q      <= k_nxt;
      s1_vld   <= vld_nxt;
      s1_first <= first_nxt;
      s1_last  <= last_nxt;
      dv_q     <= s1_vld && s1_last && !bus.I_clear;
      busy_q   <= (cnt_nxt != '0) || (vld_nxt && !last_nxt);
    end
  end

  assign bus.O_data_dv = dv_q;
  assign bus.O_busy    = busy_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    acc_lane #(.OUT_W(OUT_W)) u_lane (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .word    (bus.I_data[g*WORD_W +: 2*ADD_WIDTH]),
      .valid   (s1_vld),
      .first   (s1_first),
      .last    (s1_last),
      .clear   (bus.I_clear),
      .sum_lo  (bus.O_data[(2*g)*OUT_W +: OUT_W]),
      .sum_hi  (bus.O_data[(2*g+1)*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dsp_result_accum.sv
// Bench for dsp_result_accum: directed scenarios plus random traffic against a group-level model.
module tb_dsp_result_accum;
  import cnn_acc_pkg::*;

  localparam int unsigned CH_IN   = 16;
  localparam int unsigned PIX     = 8;
  localparam int unsigned LANES   = CH_IN * PIX;
  localparam int unsigned NCH     = 2 * LANES;
  localparam int unsigned OW      = 24;
  localparam int unsigned S_CH_IN = 2;
  localparam int unsigned S_NCH   = 2 * S_CH_IN;
  localparam int unsigned S_OW    = 20;

  logic I_clk = 1'b0;
  logic I_rst_n;

  dsp_result_accum_if #(.CH_IN(CH_IN), .PIX(PIX), .OUT_W(OW)) bus ();
  dsp_result_accum_if #(.CH_IN(S_CH_IN), .PIX(1), .OUT_W(S_OW)) sbus ();

  dsp_result_accum #(.CH_IN(CH_IN), .PIX(PIX), .OUT_W(OW)) u_dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .bus(bus));
  dsp_result_accum #(.CH_IN(S_CH_IN), .PIX(1), .OUT_W(S_OW)) u_sat (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .bus(sbus));

  always #5 I_clk = ~I_clk;

  int     n_chk = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     lo_v[LANES];
  int     hi_v[LANES];
  int     m_cnt, m_k, p_due;
  bit     p_vld, exp_pulse;
  longint m_sum[NCH];
  longint m_out[NCH];
  longint p_sums[NCH];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint lim = longint'(1) <<< (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic longint ch_main(input int c);
    return longint'($signed(bus.O_data[c*OW +: OW]));
  endfunction

  function automatic longint ch_sat(input int c);
    return longint'($signed(sbus.O_data[c*S_OW +: S_OW]));
  endfunction

  task automatic set_uniform(input int lo, input int hi);
    for (int l = 0; l < LANES; l++) begin
      lo_v[l] = lo;
      hi_v[l] = hi;
    end
  endtask

  task automatic set_random();
    for (int l = 0; l < LANES; l++) begin
      lo_v[l] = int'($urandom_range(0, 524287)) - 262144;
      hi_v[l] = int'($urandom_range(0, 524287)) - 262144;
    end
  endtask

  // Group-level reference: sum taps per channel, publish the sums one edge after the last tap.
  task automatic model_step(input bit rst_n, input bit dv, input bit clr, input int kx);
    exp_pulse = 1'b0;
    if (!rst_n) begin
      m_cnt = 0;
      p_vld = 1'b0;
      for (int c = 0; c < NCH; c++) m_out[c] = 0;
    end else if (clr) begin
      m_cnt = 0;
      p_vld = 1'b0;
    end else begin
      if (p_vld && p_due == cyc) begin
        exp_pulse = 1'b1;
        m_out     = p_sums;
        p_vld     = 1'b0;
      end
      if (dv) begin
        if (m_cnt == 0) begin
          m_k = (kx == 0) ? 1 : kx;
          for (int c = 0; c < NCH; c++) m_sum[c] = 0;
        end
        for (int l = 0; l < LANES; l++) begin
          m_sum[2*l]   += longint'(lo_v[l]);
          m_sum[2*l+1] += longint'(hi_v[l]);
        end
        m_cnt++;
        if (m_cnt == m_k) begin
          p_sums = m_sum;
          p_vld  = 1'b1;
          p_due  = cyc + 1;
          m_cnt  = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NCH*OW-1:0]     ev;
    logic [S_NCH*S_OW-1:0] sev;
    check("dv", longint'(bus.O_data_dv), longint'(exp_pulse));
    check("busy", longint'(bus.O_busy), longint'(m_cnt != 0));
    check("sat_dv", longint'(sbus.O_data_dv), longint'(exp_pulse));
    check("sat_busy", longint'(sbus.O_busy), longint'(m_cnt != 0));
    for (int c = 0; c < NCH; c++) ev[c*OW +: OW] = OW'(clampw(m_out[c], OW));
    for (int c = 0; c < S_NCH; c++) sev[c*S_OW +: S_OW] = S_OW'(clampw(m_out[c], S_OW));
    check("data_vec", longint'(bus.O_data == ev), 1);
    check("sat_data_vec", longint'(sbus.O_data == sev), 1);
    if (exp_pulse) begin
      for (int c = 0; c < NCH; c++)
        check($sformatf("ch%0d", c), ch_main(c), clampw(m_out[c], OW));
      for (int c = 0; c < S_NCH; c++)
        check($sformatf("sat_ch%0d", c), ch_sat(c), clampw(m_out[c], S_OW));
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, sample at the next falling edge.
  task automatic tick(input bit rst_n, input bit dv, input bit clr, input int kx);
    I_rst_n        = rst_n;
    bus.I_data_dv  = dv;
    bus.I_clear    = clr;
    bus.I_kx_num   = KWIDTH'(kx);
    sbus.I_data_dv = dv;
    sbus.I_clear   = clr;
    sbus.I_kx_num  = KWIDTH'(kx);
    for (int l = 0; l < LANES; l++)
      bus.I_data[l*WORD_W +: WORD_W] = {10'($urandom), 19'(hi_v[l]), 19'(lo_v[l])};
    sbus.I_data = bus.I_data[S_CH_IN*WORD_W-1:0];
    @(posedge I_clk);
    cyc++;
    model_step(rst_n, dv, clr, kx);
    @(negedge I_clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 15)));
  endtask

  initial begin
    I_rst_n = 1'b0;
    bus.I_data = '0;  bus.I_data_dv = 1'b0;  bus.I_kx_num = '0;  bus.I_clear = 1'b0;
    sbus.I_data = '0; sbus.I_data_dv = 1'b0; sbus.I_kx_num = '0; sbus.I_clear = 1'b0;
    set_uniform(0, 0);
    m_cnt = 0; m_k = 1; p_vld = 1'b0; p_due = 0;
    for (int c = 0; c < NCH; c++) begin
      m_out[c] = 0; m_sum[c] = 0; p_sums[c] = 0;
    end
    @(negedge I_clk);
    tick(1'b0, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, 1'b0, 3);

    // K=3, lo=+5, hi=-2 on every lane
    set_uniform(5, -2);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 3);
    idle(3);
    check("k3_even", ch_main(0), 15);
    check("k3_odd", ch_main(NCH - 1), -6);

    // K=1, one pulse per beat
    for (int i = 1; i <= 4; i++) begin
      set_uniform(i, 0);
      tick(1'b1, 1'b1, 1'b0, 1);
    end
    idle(2);
    check("k1_last", ch_main(2), 4);

    // K=4 with gaps, most negative field
    set_uniform(-262144, 3);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0, 4);
      idle(2);
    end
    check("k4_min", ch_main(0), -1048576);
    check("k4_hi", ch_main(1), 12);

    // Abort with I_clear, then a fresh K=2 group
    set_uniform(3, 3);
    tick(1'b1, 1'b1, 1'b0, 3);
    tick(1'b1, 1'b1, 1'b0, 3);
    tick(1'b1, 1'b1, 1'b1, 3);
    set_uniform(7, -7);
    tick(1'b1, 1'b1, 1'b0, 2);
    tick(1'b1, 1'b1, 1'b0, 2);
    idle(2);
    check("clr_new", ch_main(0), 14);
    // Clear on the edge where the pulse would be produced
    set_uniform(9, 9);
    tick(1'b1, 1'b1, 1'b0, 2);
    tick(1'b1, 1'b1, 1'b0, 2);
    tick(1'b1, 1'b0, 1'b1, 0);
    idle(2);
    check("clr_supp", ch_main(0), 14);

    // Reset in the middle of a K=5 group
    set_uniform(2, 2);
    tick(1'b1, 1'b1, 1'b0, 5);
    tick(1'b1, 1'b1, 1'b0, 5);
    tick(1'b0, 1'b1, 1'b0, 5);
    check("rst_mid", ch_main(0), 0);
    set_uniform(1, -1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 5);
    idle(2);
    check("rst_new", ch_main(0), 5);

    // K=15 at the positive limit: narrow output saturates
    set_uniform(262143, -262144);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0, 15);
    idle(2);
    check("sat_pos", ch_sat(0), 524287);
    check("sat_neg", ch_sat(1), -524288);
    check("wide_pos", ch_main(0), 3932145);

    // Random traffic: gaps, mid-group K changes, occasional clear and reset
    for (int i = 0; i < 400; i++) begin
      set_random();
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 3), int'($urandom_range(0, 15)));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
